// File: rtl/id_inst_queue_if.sv
// Handshake bundle between IF (producer), the decode-side instruction queue and EX (consumer).
interface id_inst_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [INST_WIDTH-1:0] in_inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [INST_WIDTH-1:0] out_inst;

  modport slave (
    input  in_valid, in_addr, in_inst, out_ready,
    output in_ready, out_valid, out_addr, out_inst
  );

  modport master (
    output in_valid, in_addr, in_inst, out_ready,
    input  in_ready, out_valid, out_addr, out_inst
  );
endinterface

// File: rtl/id_inst_queue.sv
// Decode-side FWFT instruction buffer: absorbs load-use stalls and EX back-pressure,
// flushes on a taken branch while optionally keeping the delay-slot instruction.
module id_inst_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  id_inst_queue_if.slave             bus,
  input  logic                       load_related_1_i,
  input  logic                       load_related_2_i,
  input  logic                       branch_flush_i,
  output logic                       stall_request_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_WIDTH-1:0]       stall_cycles_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst_q [DEPTH];

  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic head_valid_s;
  logic stall_s;
  logic out_valid_s;
  logic push_s;
  logic pop_s;
  logic flush_s;
  logic wr_en_s;

  always_comb begin
    head_valid_s = (count_q != '0);
    stall_s      = head_valid_s && (load_related_1_i || load_related_2_i);
    out_valid_s  = head_valid_s && !stall_s;
    push_s       = bus.in_valid && (count_q != CW'(DEPTH));
    pop_s        = out_valid_s && bus.out_ready;
    flush_s      = pop_s && branch_flush_i;

    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    wr_ptr_d = wr_ptr_q + PW'(push_s);
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    wr_en_s  = push_s;

    // The survivor of a delay-slot flush always sits at head+1: either the
    // already-buffered slot (count>=2) or the concurrent push landing at wr_ptr=head+1.
    if (flush_s) begin
      if (DELAY_SLOT == 0) begin
        rd_ptr_d = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = '0;
        wr_en_s  = 1'b0;
      end else if ((count_q >= CW'(2)) || push_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        wr_ptr_d = rd_ptr_q + PW'(2);
        count_d  = CW'(1);
        wr_en_s  = push_s && (count_q == CW'(1));
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        wr_ptr_d = rd_ptr_q + PW'(1);
        count_d  = '0;
        wr_en_s  = 1'b0;
      end
    end else begin
      wr_en_s = push_s;
    end

    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Entry payload is qualified by count, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_addr_q[wr_ptr_q] <= bus.in_addr;
      mem_inst_q[wr_ptr_q] <= bus.in_inst;
    end
  end

  assign bus.in_ready     = (count_q != CW'(DEPTH));
  assign bus.out_valid    = out_valid_s;
  assign bus.out_addr     = head_valid_s ? mem_addr_q[rd_ptr_q] : '0;
  assign bus.out_inst     = out_valid_s ? mem_inst_q[rd_ptr_q] : '0;
  assign stall_request_o  = stall_s;
  assign count_o          = count_q;
  assign stall_cycles_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed scenarios plus random traffic against a queue-based model,
// run on a delay-slot instance and a full-flush instance sharing the same stimulus.
module tb_id_inst_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0, ordy = 1'b0, lr1 = 1'b0, lr2 = 1'b0, bf = 1'b0;
  logic [31:0] ia = 32'd0, ii = 32'd0;

  logic        st1, st0;
  logic [2:0]  cnt1, cnt0;
  logic [15:0] sc1, sc0;

  int n_checks = 0;
  int n_err    = 0;

  ent_t mq1[$];
  ent_t mq0[$];
  int   msc1 = 0;
  int   msc0 = 0;

  always #5 clk = ~clk;

  id_inst_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus1();
  id_inst_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus0();

  assign bus1.in_valid  = iv;
  assign bus1.in_addr   = ia;
  assign bus1.in_inst   = ii;
  assign bus1.out_ready = ordy;
  assign bus0.in_valid  = iv;
  assign bus0.in_addr   = ia;
  assign bus0.in_inst   = ii;
  assign bus0.out_ready = ordy;

  id_inst_queue #(.DEPTH(DEPTH), .DELAY_SLOT(1)) u_ds1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .load_related_1_i(lr1), .load_related_2_i(lr2), .branch_flush_i(bf),
    .stall_request_o(st1), .count_o(cnt1), .stall_cycles_o(sc1)
  );

  id_inst_queue #(.DEPTH(DEPTH), .DELAY_SLOT(0)) u_ds0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .load_related_1_i(lr1), .load_related_2_i(lr2), .branch_flush_i(bf),
    .stall_request_o(st0), .count_o(cnt0), .stall_cycles_o(sc0)
  );

  // Reference: the queue as a list of entries; a flush keeps at most the instruction after the branch.
  task automatic model_next(input ent_t q[$], input bit ds, input int sc,
                            output ent_t nq[$], output int nsc);
    bit hv, stl, pop, push;
    ent_t e;
    nq  = q;
    nsc = sc;
    if (rst) begin
      nq.delete();
      nsc = 0;
    end else begin
      hv   = q.size() > 0;
      stl  = hv && (lr1 || lr2);
      pop  = hv && !stl && ordy;
      push = iv && (q.size() < DEPTH);
      e.a = ia;
      e.i = ii;
      if (stl && nsc < 65535) nsc = nsc + 1;
      if (pop && bf) begin
        nq.delete();
        if (ds) begin
          if (q.size() >= 2) nq.push_back(q[1]);
          else if (push) nq.push_back(e);
        end
      end else begin
        if (pop) void'(nq.pop_front());
        if (push) nq.push_back(e);
      end
    end
  endtask

  function automatic logic [85:0] model_out(input ent_t q[$], input int sc);
    logic hv, stl, ov;
    logic [31:0] ea, ei;
    hv  = q.size() > 0;
    stl = hv && (lr1 || lr2);
    ov  = hv && !stl;
    ea  = hv ? q[0].a : 32'd0;
    ei  = ov ? q[0].i : 32'd0;
    return {ov, ea, ei, (q.size() != DEPTH), stl, 3'(q.size()), 16'(sc)};
  endfunction

  task automatic step();
    ent_t n1[$];
    ent_t n0[$];
    int s1, s0;
    model_next(mq1, 1'b1, msc1, n1, s1);
    model_next(mq0, 1'b0, msc0, n0, s0);
    @(posedge clk);
    mq1 = n1; mq0 = n0; msc1 = s1; msc0 = s0;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] i);
    iv = 1'b1; ia = a; ii = i;
    step();
    iv = 1'b0;
  endtask

  task automatic drain();
    iv = 1'b0; bf = 1'b0; lr1 = 1'b0; lr2 = 1'b0; ordy = 1'b1;
    repeat (DEPTH + 1) step();
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", cnt1); end
    n_checks++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus1.out_valid); end
    n_checks++; if (bus1.out_addr !== 32'd0 || bus1.out_inst !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %h/%h exp 0/0", bus1.out_addr, bus1.out_inst); end
    n_checks++; if (bus1.in_ready !== 1'b1 || st1 !== 1'b0 || sc1 !== 16'd0) begin n_err++; $display("FAIL reset_misc got rdy=%b st=%b sc=%0d exp 1/0/0", bus1.in_ready, st1, sc1); end
  endtask

  task automatic test_push_basic();
    ordy = 1'b0;
    push_one(32'h0040_0000, 32'h2401_0001);
    #1;
    n_checks++; if (bus1.out_addr !== 32'h0040_0000) begin n_err++; $display("FAIL fwft_first got %h exp 00400000", bus1.out_addr); end
    push_one(32'h0040_0004, 32'h2402_0002);
    #1;
    n_checks++; if (cnt1 !== 3'd2) begin n_err++; $display("FAIL push2_count got %0d exp 2", cnt1); end
    n_checks++; if (bus1.out_addr !== 32'h0040_0000 || bus1.out_inst !== 32'h2401_0001) begin n_err++; $display("FAIL push2_head got %h/%h exp 00400000/24010001", bus1.out_addr, bus1.out_inst); end
    drain();
  endtask

  task automatic test_fill_drain();
    ordy = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_one(32'h1000 + 32'(4 * k), 32'hA000 + 32'(k));
    #1;
    n_checks++; if (cnt1 !== 3'd4 || bus1.in_ready !== 1'b0) begin n_err++; $display("FAIL full got cnt=%0d rdy=%b exp 4/0", cnt1, bus1.in_ready); end
    push_one(32'h2222, 32'h3333);
    #1;
    n_checks++; if (cnt1 !== 3'd4 || bus1.out_addr !== 32'h1000) begin n_err++; $display("FAIL full_reject got cnt=%0d head=%h exp 4/1000", cnt1, bus1.out_addr); end
    ordy = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      n_checks++; if (bus1.out_addr !== 32'h1000 + 32'(4 * k) || bus1.out_inst !== 32'hA000 + 32'(k)) begin n_err++; $display("FAIL drain_order[%0d] got %h/%h exp %h/%h", k, bus1.out_addr, bus1.out_inst, 32'h1000 + 32'(4 * k), 32'hA000 + 32'(k)); end
      step();
    end
    #1;
    n_checks++; if (cnt1 !== 3'd0 || bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt=%0d v=%b exp 0/0", cnt1, bus1.out_valid); end
    ordy = 1'b0;
  endtask

  task automatic test_stall();
    push_one(32'h2000, 32'h1234_5678);
    ordy = 1'b1; lr1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (st1 !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.out_inst !== 32'd0 || bus1.out_addr !== 32'h2000) begin n_err++; $display("FAIL stall_hold[%0d] got st=%b v=%b inst=%h addr=%h exp 1/0/0/2000", k, st1, bus1.out_valid, bus1.out_inst, bus1.out_addr); end
      step();
    end
    lr1 = 1'b0;
    #1;
    n_checks++; if (sc1 !== 16'd3) begin n_err++; $display("FAIL stall_cycles got %0d exp 3", sc1); end
    n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_inst !== 32'h1234_5678 || st1 !== 1'b0) begin n_err++; $display("FAIL stall_release got v=%b inst=%h exp 1/12345678", bus1.out_valid, bus1.out_inst); end
    step();
    #1;
    n_checks++; if (cnt1 !== 3'd0) begin n_err++; $display("FAIL stall_issue got cnt=%0d exp 0", cnt1); end
    ordy = 1'b0;
  endtask

  task automatic test_flush_multi();
    ordy = 1'b0;
    push_one(32'h100, 32'hB);
    push_one(32'h104, 32'h5);
    push_one(32'h108, 32'hC);
    ordy = 1'b1; bf = 1'b1; iv = 1'b1; ia = 32'h10C; ii = 32'hD;
    #1;
    n_checks++; if (bus1.out_addr !== 32'h100 || bus1.out_valid !== 1'b1) begin n_err++; $display("FAIL flush3_pre got %h v=%b exp 100/1", bus1.out_addr, bus1.out_valid); end
    step();
    iv = 1'b0; bf = 1'b0; ordy = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 3'd1 || bus1.out_addr !== 32'h104 || bus1.out_inst !== 32'h5) begin n_err++; $display("FAIL flush3_ds1 got cnt=%0d head=%h/%h exp 1/104/5", cnt1, bus1.out_addr, bus1.out_inst); end
    n_checks++; if (cnt0 !== 3'd0 || bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush3_ds0 got cnt=%0d v=%b exp 0/0", cnt0, bus0.out_valid); end
    drain();
  endtask

  task automatic test_flush_single();
    ordy = 1'b0;
    push_one(32'h100, 32'hB);
    ordy = 1'b1; bf = 1'b1; iv = 1'b1; ia = 32'h104; ii = 32'h5;
    step();
    iv = 1'b0; bf = 1'b0; ordy = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 3'd1 || bus1.out_addr !== 32'h104) begin n_err++; $display("FAIL flush1_ds1 got cnt=%0d head=%h exp 1/104", cnt1, bus1.out_addr); end
    n_checks++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL flush1_ds0 got cnt=%0d exp 0", cnt0); end
    ordy = 1'b1; bf = 1'b1;
    step();
    bf = 1'b0; ordy = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 3'd0) begin n_err++; $display("FAIL flush1_noslot got cnt=%0d exp 0", cnt1); end
    drain();
  endtask

  task automatic test_reset_midstream();
    ordy = 1'b0;
    push_one(32'h300, 32'h1);
    push_one(32'h304, 32'h2);
    push_one(32'h308, 32'h3);
    rst = 1'b1; iv = 1'b1; ia = 32'h30C; ii = 32'h4;
    step();
    rst = 1'b0; iv = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 3'd0 || bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ds1 got cnt=%0d v=%b rdy=%b exp 0/0/1", cnt1, bus1.out_valid, bus1.in_ready); end
    n_checks++; if (cnt0 !== 3'd0 || sc0 !== 16'd0) begin n_err++; $display("FAIL rst_mid_ds0 got cnt=%0d sc=%0d exp 0/0", cnt0, sc0); end
  endtask

  task automatic test_random();
    logic [85:0] exp1, exp0;
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ia   = $urandom;
      ii   = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      lr1  = ($urandom_range(0, 7) == 0);
      lr2  = ($urandom_range(0, 9) == 0);
      bf   = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      #1;
      exp1 = model_out(mq1, msc1);
      exp0 = model_out(mq0, msc0);
      n_checks++; if ({bus1.out_valid, bus1.out_addr, bus1.out_inst, bus1.in_ready, st1, cnt1, sc1} !== exp1) begin n_err++; $display("FAIL rand_ds1[%0d] got %h exp %h", n, {bus1.out_valid, bus1.out_addr, bus1.out_inst, bus1.in_ready, st1, cnt1, sc1}, exp1); end
      n_checks++; if ({bus0.out_valid, bus0.out_addr, bus0.out_inst, bus0.in_ready, st0, cnt0, sc0} !== exp0) begin n_err++; $display("FAIL rand_ds0[%0d] got %h exp %h", n, {bus0.out_valid, bus0.out_addr, bus0.out_inst, bus0.in_ready, st0, cnt0, sc0}, exp0); end
      step();
    end
    rst = 1'b0; iv = 1'b0; bf = 1'b0; lr1 = 1'b0; lr2 = 1'b0; ordy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_push_basic();
    test_fill_drain();
    test_stall();
    test_flush_multi();
    test_flush_single();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
